// File: rtl/io_pkg.sv
// Shared definitions for the IO controller: input-handshake FSM encoding and
// the active-low seven-segment glyph table ({g,f,e,d,c,b,a}).
package io_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      DONE         = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   // Entry 15 (F) first, entry 0 last.
   localparam logic [15:0][6:0] SEG_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex_to_seg.sv
// One hex nibble to an active-low seven-segment glyph.
module hex_to_seg
   import io_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_GLYPH[i_nibble];

endmodule

// File: rtl/io_controller.sv
// CPU-facing IO block: debounced Enter-button input handshake, latched
// eight-digit hex display and a sticky halt flag.
module io_controller
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
)
(
   input  logic        CLK,
   input  logic        reset,
   input  logic        in_req,
   input  logic        out_req,
   input  logic        halt,
   input  logic        enter,
   input  logic [9:0]  sw,
   input  logic [31:0] out_data,
   output logic [31:0] in_data,
   output logic        stall,
   output logic        halted,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6,
   output logic [6:0]  hex7
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_debLevel;
   logic [CNT_W-1:0] r_debCount;
   state_t           r_state;
   state_t           w_nextState;
   logic [31:0]      r_inData;
   logic [31:0]      r_display;
   logic             r_halted;
   logic             w_debFlip;
   logic             w_debRise;
   logic             w_latchIn;
   logic             w_latchDisp;
   logic [6:0]       w_seg [8];

   // The flip fires on the edge that completes the run of differing samples.
   assign w_debFlip   = (r_sync2 != r_debLevel) &&
                        (r_debCount == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign w_debRise   = w_debFlip && r_sync2;
   assign w_latchDisp = out_req && !in_req && !r_halted;

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_debLevel <= 1'b0;
         r_debCount <= '0;
      end else begin
         r_sync1 <= enter;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_debLevel) begin
            r_debCount <= '0;
         end else if (w_debFlip) begin
            r_debLevel <= r_sync2;
            r_debCount <= '0;
         end else begin
            r_debCount <= r_debCount + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state   <= IDLE;
         r_inData  <= '0;
         r_display <= '0;
         r_halted  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_latchIn) begin
            r_inData <= {22'b0, sw};
         end
         if (w_latchDisp) begin
            r_display <= out_data;
         end
         if (halt) begin
            r_halted <= 1'b1;
         end
      end
   end

   // Only a fresh rising edge of the debounced level counts as a press, so a
   // button still held from an earlier Input cannot complete a new one.
   always_comb begin
      w_nextState = r_state;
      w_latchIn   = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_req && !r_halted) begin
               w_nextState = WAIT_PRESS;
            end
         end
         WAIT_PRESS: begin
            if (r_halted) begin
               w_nextState = IDLE;
            end else if (w_debRise) begin
               w_nextState = DONE;
               w_latchIn   = 1'b1;
            end
         end
         DONE: begin
            w_nextState = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (!r_debLevel) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign stall   = in_req && !r_halted && (r_state != DONE);
   assign in_data = r_inData;
   assign halted  = r_halted;

   for (genvar g = 0; g < 8; g++) begin : gen_hex
      hex_to_seg u_hexToSeg (
         .i_nibble (r_display[4*g +: 4]),
         .o_seg    (w_seg[g])
      );
   end

   assign hex0 = w_seg[0];
   assign hex1 = w_seg[1];
   assign hex2 = w_seg[2];
   assign hex3 = w_seg[3];
   assign hex4 = w_seg[4];
   assign hex5 = w_seg[5];
   assign hex6 = w_seg[6];
   assign hex7 = w_seg[7];

endmodule
